res_stream_out: RTL and testbench



---
 rtl/res_stream_out_pkg.sv | 15 +
 rtl/res_skid_fifo.sv | 46 ++++
 rtl/res_stream_out.sv | 129 ++++++++++++
 tb/tb_res_stream_out.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/res_stream_out_pkg.sv
// rtl/res_stream_out_pkg.sv - shared coprocessor constants and result-stream FSM encodings
package res_stream_out_pkg;

  localparam int width          = 8;
  localparam int RES_depth_bits = 6;
  localparam int M              = 64;
  localparam int AXIS_width     = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

endpackage

// File: rtl/res_skid_fifo.sv
// rtl/res_skid_fifo.sv - two-entry {last, data} buffer between RES_RAM reads and the AXIS master
module res_skid_fifo #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  push_last,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic                  head_last,
  output logic [data_width-1:0] head_data,
  output logic [1:0]            occ
);

  logic [data_width:0] mem [2];
  logic                wr_ptr;
  logic                rd_ptr;

  // Ring of two entries; the caller never pushes when full nor pops when empty
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign {head_last, head_data} = mem[rd_ptr];

endmodule

// File: rtl/res_stream_out.sv
// rtl/res_stream_out.sv - streams the M result bytes from RES_RAM out on the AXIS master port
module res_stream_out #(
  parameter int width          = res_stream_out_pkg::width,
  parameter int RES_depth_bits = res_stream_out_pkg::RES_depth_bits,
  parameter int M              = res_stream_out_pkg::M,
  parameter int AXIS_width     = res_stream_out_pkg::AXIS_width
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Done,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic                      M_AXIS_TVALID,
  output logic [AXIS_width-1:0]     M_AXIS_TDATA,
  output logic                      M_AXIS_TLAST,
  input  logic                      M_AXIS_TREADY,
  output logic                      busy,
  output logic                      stream_done
);

  import res_stream_out_pkg::*;

  // rd_cnt must reach M itself, so it carries one bit more than the address
  localparam int CW = RES_depth_bits + 1;
  localparam logic [CW-1:0]             RD_END  = CW'(M);
  localparam logic [CW-1:0]             RD_LAST = CW'(M - 1);
  localparam logic [RES_depth_bits-1:0] TX_LAST = RES_depth_bits'(M - 1);

  state_t                    state;
  logic                      done_q;
  logic [CW-1:0]             rd_cnt;
  logic [RES_depth_bits-1:0] tx_cnt;
  logic                      inflight;
  logic                      inflight_last;
  logic [1:0]                occ;
  logic                      head_last;
  logic [width-1:0]          head_data;
  logic                      trigger;
  logic                      pop;
  logic                      issue;

  assign trigger = Done & ~done_q;
  assign M_AXIS_TVALID = (occ != 2'd0);
  assign pop = M_AXIS_TVALID & M_AXIS_TREADY;

  // A read may be issued only if its data is sure to find a free slot when it returns
  assign issue = (state == ST_STREAM) && (rd_cnt < RD_END) &&
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign RES_read_en      = issue;
  assign RES_read_address = rd_cnt[RES_depth_bits-1:0];
  assign M_AXIS_TDATA     = AXIS_width'(head_data);
  assign M_AXIS_TLAST     = M_AXIS_TVALID & head_last;
  assign busy             = (state == ST_STREAM);
  assign stream_done      = (state == ST_FINISH);

  // Registered copy of Done so only its rising edge starts a stream
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= Done;
    end
  end

  // Read-pipeline tracking: the RAM answers one cycle after each issued read
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (rd_cnt == RD_LAST);
    end
  end

  // Stream FSM with read and accepted-beat counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rd_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state  <= ST_STREAM;
            rd_cnt <= '0;
            tx_cnt <= '0;
          end
        end
        ST_STREAM: begin
          if (issue) begin
            rd_cnt <= rd_cnt + CW'(1);
          end
          if (pop) begin
            if (tx_cnt == TX_LAST) begin
              state <= ST_FINISH;
            end else begin
              tx_cnt <= tx_cnt + RES_depth_bits'(1);
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  res_skid_fifo #(
    .data_width (width)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_last (inflight_last),
    .push_data (RES_read_data_out),
    .pop       (pop),
    .head_last (head_last),
    .head_data (head_data),
    .occ       (occ)
  );

endmodule

// File: tb/tb_res_stream_out.sv
// tb/tb_res_stream_out.sv - directed self-checking bench for res_stream_out
module tb_res_stream_out;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        done;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;
  logic        busy;
  logic        sdone;

  logic        done1;
  logic        rd_en1;
  logic [5:0]  rd_addr1;
  logic [7:0]  rd_data1;
  logic        tvalid1;
  logic [31:0] tdata1;
  logic        tlast1;
  logic        tready1;
  logic        busy1;
  logic        sdone1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;
  int beats, reads, pulses, exp_beat, exp_rd, first_hs, last_hs, t1;

  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic        prev_l = 1'b0;
  logic [31:0] prev_d = '0;

  res_stream_out dut (
    .clk (clk), .reset (reset), .Done (done),
    .RES_read_en (rd_en), .RES_read_address (rd_addr), .RES_read_data_out (rd_data),
    .M_AXIS_TVALID (tvalid), .M_AXIS_TDATA (tdata), .M_AXIS_TLAST (tlast),
    .M_AXIS_TREADY (tready), .busy (busy), .stream_done (sdone)
  );

  res_stream_out #(.M (1)) dut1 (
    .clk (clk), .reset (reset), .Done (done1),
    .RES_read_en (rd_en1), .RES_read_address (rd_addr1), .RES_read_data_out (rd_data1),
    .M_AXIS_TVALID (tvalid1), .M_AXIS_TDATA (tdata1), .M_AXIS_TLAST (tlast1),
    .M_AXIS_TREADY (tready1), .busy (busy1), .stream_done (sdone1)
  );

  // RES_RAM models: RES[k] = k for the full build, RES[0] = 0xA5 for the M=1 build
  always @(posedge clk) begin
    if (rd_en) rd_data <= {2'b00, rd_addr};
    if (rd_en1) rd_data1 <= (rd_addr1 == 6'd0) ? 8'hA5 : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_stream();
    beats = 0; reads = 0; pulses = 0; exp_beat = 0; exp_rd = 0;
    first_hs = -1; last_hs = -1;
  endtask

  task automatic cyc(input logic rdy);
    @(negedge clk);
    tready = rdy;
    #1;
    cyc_no++;
    if (prev_v && !prev_r) begin
      chk("hold_valid", 32'(tvalid), 32'd1);
      chk("hold_data", tdata, prev_d);
      chk("hold_last", 32'(tlast), 32'(prev_l));
    end
    if (!busy) chk("rd_idle", 32'(rd_en), 32'd0);
    if (rd_en) begin
      chk("rd_addr", 32'(rd_addr), 32'(exp_rd));
      exp_rd++;
      reads++;
    end
    if (sdone) begin
      pulses++;
      chk("done_after_last", 32'(cyc_no), 32'(last_hs + 1));
      chk("busy_at_done", 32'(busy), 32'd0);
    end
    if (tvalid && tready) begin
      chk("beat_data", tdata, 32'(exp_beat));
      chk("beat_last", 32'(tlast), 32'(exp_beat == 63));
      if (beats == 0) first_hs = cyc_no;
      last_hs = cyc_no;
      beats++;
      exp_beat++;
    end
    prev_v = tvalid; prev_r = tready; prev_d = tdata; prev_l = tlast;
  endtask

  initial begin
    reset = 1'b1; done = 1'b0; done1 = 1'b0; tready = 1'b0; tready1 = 1'b1;
    start_stream();
    cyc(0); cyc(0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sdone", 32'(sdone), 32'd0);
    reset = 1'b0;
    cyc(0);

    // full-throughput stream and trigger latency
    start_stream();
    done = 1'b1;
    cyc(1);
    t1 = cyc_no;
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_rd_en", 32'(rd_en), 32'd1);
    chk("lat_tvalid1", 32'(tvalid), 32'd0);
    cyc(1);
    chk("lat_tvalid2", 32'(tvalid), 32'd0);
    chk("lat_rd_en2", 32'(rd_en), 32'd1);
    cyc(1);
    chk("lat_tvalid3", 32'(tvalid), 32'd1);
    for (int g = 0; g < 200 && pulses == 0; g++) cyc(1);
    chk("s1_beats", 32'(beats), 32'd64);
    chk("s1_reads", 32'(reads), 32'd64);
    chk("s1_pulses", 32'(pulses), 32'd1);
    chk("s1_first", 32'(first_hs), 32'(t1 + 2));
    chk("s1_span", 32'(last_hs - first_hs), 32'd63);

    // Done held high: no retrigger
    for (int g = 0; g < 100; g++) cyc(1);
    chk("hold_reads", 32'(reads), 32'd64);
    chk("hold_beats", 32'(beats), 32'd64);
    chk("hold_pulses", 32'(pulses), 32'd1);

    // second rising edge, TREADY toggling
    start_stream();
    done = 1'b0;
    cyc(1);
    done = 1'b1;
    for (int g = 0; g < 400 && pulses == 0; g++) cyc(g % 2 == 0);
    chk("s2_beats", 32'(beats), 32'd64);
    chk("s2_reads", 32'(reads), 32'd64);
    chk("s2_pulses", 32'(pulses), 32'd1);

    // long stall on beat 10
    start_stream();
    done = 1'b0;
    cyc(1);
    done = 1'b1;
    for (int g = 0; g < 200 && exp_beat < 10; g++) cyc(1);
    chk("s3_at10", 32'(exp_beat), 32'd10);
    for (int i = 0; i < 20; i++) begin
      cyc(0);
      chk("s3_hold_v", 32'(tvalid), 32'd1);
      chk("s3_hold_d", tdata, 32'd10);
      if (i >= 2) chk("s3_no_rd", 32'(rd_en), 32'd0);
    end
    for (int g = 0; g < 400 && pulses == 0; g++) cyc(1);
    chk("s3_beats", 32'(beats), 32'd64);
    chk("s3_reads", 32'(reads), 32'd64);
    chk("s3_pulses", 32'(pulses), 32'd1);

    // reset mid-stream, then restart from address 0
    start_stream();
    done = 1'b0;
    cyc(1);
    done = 1'b1;
    for (int g = 0; g < 200 && exp_beat < 31; g++) cyc(1);
    chk("s5_at31", 32'(exp_beat), 32'd31);
    reset = 1'b1;
    done = 1'b0;
    cyc(1);
    chk("mid_rd_en", 32'(rd_en), 32'd0);
    chk("mid_rd_addr", 32'(rd_addr), 32'd0);
    chk("mid_tvalid", 32'(tvalid), 32'd0);
    chk("mid_tdata", tdata, 32'd0);
    chk("mid_tlast", 32'(tlast), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_sdone", 32'(sdone), 32'd0);
    reset = 1'b0;
    cyc(1);
    start_stream();
    done = 1'b1;
    for (int g = 0; g < 400 && pulses == 0; g++) cyc(g % 3 != 0);
    chk("s5_beats", 32'(beats), 32'd64);
    chk("s5_reads", 32'(reads), 32'd64);
    chk("s5_pulses", 32'(pulses), 32'd1);

    // M=1 build
    done = 1'b0;
    done1 = 1'b1;
    cyc(1);
    chk("m1_rd_en", 32'(rd_en1), 32'd1);
    chk("m1_rd_addr", 32'(rd_addr1), 32'd0);
    chk("m1_busy", 32'(busy1), 32'd1);
    cyc(1);
    chk("m1_rd_once", 32'(rd_en1), 32'd0);
    chk("m1_tvalid2", 32'(tvalid1), 32'd0);
    cyc(1);
    chk("m1_tvalid3", 32'(tvalid1), 32'd1);
    chk("m1_tdata", tdata1, 32'h0000_00A5);
    chk("m1_tlast", 32'(tlast1), 32'd1);
    cyc(1);
    chk("m1_sdone", 32'(sdone1), 32'd1);
    chk("m1_busy_off", 32'(busy1), 32'd0);
    chk("m1_tvalid_off", 32'(tvalid1), 32'd0);
    cyc(1);
    chk("m1_sdone_off", 32'(sdone1), 32'd0);
    chk("m1_no_rd", 32'(rd_en1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
